conv_complex_loader: RTL and testbench

//   Upstream feeder for conv_complex. Accepts a serial stream of complex Q(QI.QF) samples over a valid/ready handshake.

---
 rtl/conv_complex_loader.sv | 152 +++++++++++++++
 tb/tb_conv_complex_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_complex_loader.sv
// conv_complex_loader: collects a serial stream of complex samples into a
// persistent 3-tap kernel and NUM_ELEMS-sample signal frames for conv_complex.
// It starts conv_complex with en and holds en until done, then emits a one-cycle
// frame_done and records any overflow in a sticky flag.
module conv_complex_loader #(
  parameter int QI        = 4,
  parameter int QF        = 4,
  parameter int NUM_ELEMS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sel,
  input  logic [QI+QF-1:0]              in_re,
  input  logic [QI+QF-1:0]              in_im,
  input  logic                          flush,
  output logic [2*3*(QI+QF)-1:0]        kernel,
  output logic [2*(QI+QF)*NUM_ELEMS-1:0] signal,
  output logic                          en,
  input  logic                          conv_done,
  input  logic                          conv_overflow,
  output logic                          frame_done,
  output logic                          ovf_sticky,
  output logic                          kernel_loaded
);

  localparam int W  = QI + QF;
  localparam int SW = 2 * W;                    // one packed complex sample
  localparam int CW = $clog2(NUM_ELEMS + 1);    // sig_cnt must reach NUM_ELEMS

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   sig_cnt_reg;
  logic [1:0]      tap_cnt_reg;
  logic            en_reg;
  logic            frame_done_reg;
  logic            ovf_sticky_reg;
  logic            kernel_loaded_reg;

  logic            frame_full;
  logic            xfer;
  logic            sig_wr;
  logic            kern_wr;
  logic [SW-1:0]   sample;

  // A full frame only blocks signal samples; kernel taps keep flowing while filling.
  assign frame_full = (sig_cnt_reg == CW'(NUM_ELEMS));
  assign in_ready   = (state_reg == FILL) && (in_sel || !frame_full);
  assign xfer       = in_valid && in_ready;
  // A flush discards any signal sample arriving in the same cycle.
  assign sig_wr     = xfer && !in_sel && !flush;
  assign kern_wr    = xfer && in_sel;
  assign sample     = {in_re, in_im};

  assign en            = en_reg;
  assign frame_done    = frame_done_reg;
  assign ovf_sticky    = ovf_sticky_reg;
  assign kernel_loaded = kernel_loaded_reg;

  // Frame sequencing: fill counters, launch conv_complex, wait for done, drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= FILL;
      sig_cnt_reg       <= '0;
      tap_cnt_reg       <= '0;
      en_reg            <= 1'b0;
      frame_done_reg    <= 1'b0;
      ovf_sticky_reg    <= 1'b0;
      kernel_loaded_reg <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          frame_done_reg <= 1'b0;
          if (kern_wr) begin
            tap_cnt_reg <= (tap_cnt_reg == 2'd2) ? 2'd0 : tap_cnt_reg + 2'd1;
            if (tap_cnt_reg == 2'd0) begin
              kernel_loaded_reg <= 1'b0;
            end else if (tap_cnt_reg == 2'd2) begin
              kernel_loaded_reg <= 1'b1;
            end
          end
          if (flush) begin
            sig_cnt_reg <= '0;
          end else if (sig_wr) begin
            sig_cnt_reg <= sig_cnt_reg + CW'(1);
          end else if (frame_full && kernel_loaded_reg) begin
            state_reg <= RUN;
            en_reg    <= 1'b1;
          end
        end
        RUN: begin
          if (conv_done) begin
            ovf_sticky_reg <= ovf_sticky_reg | conv_overflow;
            en_reg         <= 1'b0;
            frame_done_reg <= 1'b1;
            state_reg      <= DRAIN;
          end
        end
        DRAIN: begin
          frame_done_reg <= 1'b0;
          sig_cnt_reg    <= '0;
          state_reg      <= FILL;
        end
        default: begin
          en_reg         <= 1'b0;
          frame_done_reg <= 1'b0;
          state_reg      <= FILL;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_ELEMS; gi++) begin : g_sig
      logic [SW-1:0] slot_reg;

      // Signal slot gi captures the gi-th sample of the frame; first sample at the LSB.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          slot_reg <= '0;
        end else if (sig_wr && (sig_cnt_reg == CW'(gi))) begin
          slot_reg <= sample;
        end
      end

      assign signal[SW*gi +: SW] = slot_reg;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_kern
      logic [SW-1:0] tap_reg;

      // Kernel tap gi persists across frames until the same tap is rewritten.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          tap_reg <= '0;
        end else if (kern_wr && (tap_cnt_reg == 2'(gi))) begin
          tap_reg <= sample;
        end
      end

      // First tap received sits at the MSB end of the kernel bus.
      assign kernel[SW*(2-gi) +: SW] = tap_reg;
    end
  endgenerate

endmodule

// File: tb/tb_conv_complex_loader.sv
// Directed bench for conv_complex_loader with hand-computed expectations.
module tb_conv_complex_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sel;
  logic [7:0]  in_re;
  logic [7:0]  in_im;
  logic        flush;
  logic [47:0] kernel;
  logic [47:0] signal;
  logic        en;
  logic        conv_done;
  logic        conv_overflow;
  logic        frame_done;
  logic        ovf_sticky;
  logic        kernel_loaded;

  int vectors;
  int miscompares;

  conv_complex_loader #(.QI(4), .QF(4), .NUM_ELEMS(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sel        (in_sel),
    .in_re         (in_re),
    .in_im         (in_im),
    .flush         (flush),
    .kernel        (kernel),
    .signal        (signal),
    .en            (en),
    .conv_done     (conv_done),
    .conv_overflow (conv_overflow),
    .frame_done    (frame_done),
    .ovf_sticky    (ovf_sticky),
    .kernel_loaded (kernel_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
  endtask

  // Called 1ns after a rising edge; returns 1ns after the accepting edge.
  task automatic send(input logic sel, input logic [7:0] re, input logic [7:0] im);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_re    = re;
    in_im    = im;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk($sformatf("accept sel=%0d %h%h", sel, re, im), {47'd0, ok}, 48'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b0;
    in_valid      = 1'b0;
    in_sel        = 1'b0;
    in_re         = 8'h00;
    in_im         = 8'h00;
    flush         = 1'b0;
    conv_done     = 1'b0;
    conv_overflow = 1'b0;

    // Reset state
    #1;
    chk("rst_en", {47'd0, en}, 48'd0);
    chk("rst_kernel", kernel, 48'd0);
    chk("rst_signal", signal, 48'd0);
    chk("rst_flags", {45'd0, frame_done, ovf_sticky, kernel_loaded}, 48'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Test 1: kernel then signal, en one cycle after last accept
    send(1'b1, 8'h04, 8'h20);
    chk("t1_loaded_after_tap0", {47'd0, kernel_loaded}, 48'd0);
    send(1'b1, 8'h12, 8'hF0);
    send(1'b1, 8'h00, 8'hF4);
    chk("t1_loaded", {47'd0, kernel_loaded}, 48'd1);
    chk("t1_kernel", kernel, 48'h042012F000F4);
    send(1'b0, 8'h28, 8'hFC);
    send(1'b0, 8'hFA, 8'h14);
    send(1'b0, 8'h11, 8'hD0);
    chk("t1_en_at_last_accept", {47'd0, en}, 48'd0);
    chk("t1_signal", signal, 48'h11D0FA1428FC);
    tick();
    chk("t1_en_rise", {47'd0, en}, 48'd1);
    chk("t1_ready_run", {47'd0, in_ready}, 48'd0);

    // Test 2: en held 5 cycles, done with overflow, drain then FILL
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t2_en_hold%0d", i), {47'd0, en}, 48'd1);
    end
    conv_done     = 1'b1;
    conv_overflow = 1'b1;
    tick();
    conv_done     = 1'b0;
    conv_overflow = 1'b0;
    chk("t2_drain_en", {47'd0, en}, 48'd0);
    chk("t2_drain_fd", {47'd0, frame_done}, 48'd1);
    chk("t2_ovf", {47'd0, ovf_sticky}, 48'd1);
    chk("t2_drain_ready", {47'd0, in_ready}, 48'd0);
    tick();
    chk("t2_fill_fd", {47'd0, frame_done}, 48'd0);
    chk("t2_fill_ready", {47'd0, in_ready}, 48'd1);
    chk("t2_kernel_persist", kernel, 48'h042012F000F4);

    // Test 4: two samples, flush with a discarded sample, three new samples
    send(1'b0, 8'h99, 8'hAA);
    send(1'b0, 8'hBB, 8'hCC);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_re    = 8'hDD;
    in_im    = 8'hEE;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t4_en_after_flush", {47'd0, en}, 48'd0);
    send(1'b0, 8'h33, 8'h44);
    chk("t4_en_c", {47'd0, en}, 48'd0);
    send(1'b0, 8'h55, 8'h66);
    chk("t4_en_d", {47'd0, en}, 48'd0);
    send(1'b0, 8'h77, 8'h88);
    chk("t4_en_e", {47'd0, en}, 48'd0);
    tick();
    chk("t4_en_rise", {47'd0, en}, 48'd1);
    chk("t4_signal", signal, 48'h778855663344);

    // Test 5: in_valid held during RUN
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_re    = 8'hAA;
    in_im    = 8'hBB;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t5_ready_sig%0d", i), {47'd0, in_ready}, 48'd0);
      tick();
      chk($sformatf("t5_signal%0d", i), signal, 48'h778855663344);
    end
    in_sel = 1'b1;
    #1;
    chk("t5_ready_tap", {47'd0, in_ready}, 48'd0);
    tick();
    chk("t5_kernel", kernel, 48'h042012F000F4);
    chk("t5_loaded", {47'd0, kernel_loaded}, 48'd1);
    in_valid = 1'b0;
    in_sel   = 1'b0;
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("t5_drain_fd", {47'd0, frame_done}, 48'd1);
    chk("t5_ovf_sticky", {47'd0, ovf_sticky}, 48'd1);
    tick();
    chk("t5_fill_ready", {47'd0, in_ready}, 48'd1);

    // Test 6: reset in the middle of RUN
    send(1'b0, 8'h01, 8'h02);
    send(1'b0, 8'h03, 8'h04);
    send(1'b0, 8'h05, 8'h06);
    tick();
    chk("t6_en_run", {47'd0, en}, 48'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_en_async", {47'd0, en}, 48'd0);
    chk("t6_loaded", {47'd0, kernel_loaded}, 48'd0);
    chk("t6_ovf", {47'd0, ovf_sticky}, 48'd0);
    chk("t6_kernel", kernel, 48'd0);
    chk("t6_signal", signal, 48'd0);
    tick();
    rst = 1'b1;
    tick();

    // Test 3: signal before kernel; 4th sample stalls until kernel loads
    send(1'b0, 8'h10, 8'h20);
    send(1'b0, 8'h30, 8'h40);
    send(1'b0, 8'h50, 8'h60);
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_re    = 8'h70;
    in_im    = 8'h80;
    #1;
    chk("t3_stall_ready", {47'd0, in_ready}, 48'd0);
    tick();
    chk("t3_stall_en", {47'd0, en}, 48'd0);
    tick();
    chk("t3_stall_ready2", {47'd0, in_ready}, 48'd0);
    chk("t3_signal_hold", signal, 48'h506030401020);
    in_valid = 1'b0;
    send(1'b1, 8'h01, 8'h02);
    send(1'b1, 8'h03, 8'h04);
    chk("t3_en_two_taps", {47'd0, en}, 48'd0);
    send(1'b1, 8'h05, 8'h06);
    chk("t3_en_last_tap", {47'd0, en}, 48'd0);
    tick();
    chk("t3_en_rise", {47'd0, en}, 48'd1);
    chk("t3_kernel", kernel, 48'h010203040506);
    chk("t3_signal", signal, 48'h506030401020);
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("t3_drain_fd", {47'd0, frame_done}, 48'd1);
    chk("t3_ovf", {47'd0, ovf_sticky}, 48'd0);
    tick();
    chk("t3_fill_en", {47'd0, en}, 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
